// File: rtl/ad9228_readout_sched_if.sv
// ============================================================================
//  Module      : ad9228_readout_sched_if
//  Description : Bus bundle between the readout scheduler, the capture block's
//                per-channel FIFO read mux and the downstream sample stream.
//  Ports       : (interface signals)
//                fifo_addr      - channel select to the FIFO read mux
//                fifo_rd_en     - one-hot FIFO read strobe
//                fifo_not_empty - muxed not-empty flag for fifo_addr
//                fifo_full      - muxed full flag for fifo_addr
//                fifo_dout      - muxed FIFO data, valid one cycle after strobe
//                m_tdata        - {channel, sample}
//                m_tuser_first  - first word of a burst
//                m_tvalid       - stream valid
//                m_tready       - stream ready
//                master modport = scheduler view, slave modport = peer view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ad9228_readout_sched_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
);
    logic [CH_W-1:0]            fifo_addr;
    logic [NUM_CHANNELS-1:0]    fifo_rd_en;
    logic                       fifo_not_empty;
    logic                       fifo_full;
    logic [DATA_WIDTH-1:0]      fifo_dout;
    logic [CH_W+DATA_WIDTH-1:0] m_tdata;
    logic                       m_tuser_first;
    logic                       m_tvalid;
    logic                       m_tready;

    modport master (
        output fifo_addr, fifo_rd_en, m_tdata, m_tuser_first, m_tvalid,
        input  fifo_not_empty, fifo_full, fifo_dout, m_tready
    );

    modport slave (
        input  fifo_addr, fifo_rd_en, m_tdata, m_tuser_first, m_tvalid,
        output fifo_not_empty, fifo_full, fifo_dout, m_tready
    );
endinterface

`default_nettype wire

// File: rtl/ad9228_readout_sched.sv
// ============================================================================
//  Module      : ad9228_readout_sched
//  Description : Round-robin readout scheduler for the AD9228 per-channel
//                sample FIFOs. Drains each enabled channel in bursts of up to
//                BURST_LEN words and emits every sample on a valid/ready
//                stream tagged with its channel number and a first-of-burst
//                flag. Runs entirely in the FIFO read-clock domain.
//  Ports       : clk             - FIFO read clock
//                rstn            - synchronous active-low reset
//                enable_i        - scheduler run enable
//                ch_mask_i       - per-channel participation mask
//                clear_status_i  - clears overflow_seen_o and words_sent_o
//                bus             - FIFO read side + output stream (master)
//                busy_o          - FSM not idle
//                overflow_seen_o - sticky per-channel FIFO-full flags
//                words_sent_o    - completed stream handshakes (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad9228_readout_sched #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 12,
    parameter int BURST_LEN    = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rstn,
    input  wire logic                     enable_i,
    input  wire logic [NUM_CHANNELS-1:0]  ch_mask_i,
    input  wire logic                     clear_status_i,
    ad9228_readout_sched_if.master        bus,
    output logic                          busy_o,
    output logic [NUM_CHANNELS-1:0]       overflow_seen_o,
    output logic [31:0]                   words_sent_o
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;

    localparam logic [CH_W-1:0]  c_ptr_last   = CH_W'(NUM_CHANNELS - 1);
    localparam logic [CNT_W-1:0] c_burst_last = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_CHECK  = 3'd2,
        S_FETCH  = 3'd3,
        S_LOAD   = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t                     state_q;
    logic [CH_W-1:0]            ptr_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [CH_W+DATA_WIDTH-1:0] tdata_q;
    logic                       first_q;
    logic [NUM_CHANNELS-1:0]    overflow_q;
    logic [31:0]                words_q;

    logic [CH_W-1:0]            ptr_adv_d;
    logic [NUM_CHANNELS-1:0]    rd_strobe;
    logic                       handshake;
    logic                       burst_last;

    // Pointer advance with explicit wrap so non-power-of-two channel counts
    // never select a nonexistent FIFO.
    assign ptr_adv_d  = (ptr_q == c_ptr_last) ? '0 : ptr_q + CH_W'(1);
    assign handshake  = (state_q == S_OUT) && bus.m_tready;
    assign burst_last = (cnt_q == c_burst_last);

    // Read strobe is decoded from registered state only: high for exactly the
    // single FETCH cycle on the currently selected channel.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_rd_en
        assign rd_strobe[gi] = (state_q == S_FETCH) && (ptr_q == CH_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tdata_q    <= '0;
            first_q    <= 1'b0;
            overflow_q <= '0;
            words_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q <= S_SELECT;
                    end
                end
                // One cycle for the capture block's address mux to settle
                // before its flags are trusted.
                S_SELECT: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (!enable_i) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (ch_mask_i[ptr_q] && bus.fifo_not_empty) begin
                        state_q <= S_FETCH;
                    end else begin
                        ptr_q   <= ptr_adv_d;
                        cnt_q   <= '0;
                        state_q <= S_SELECT;
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    tdata_q <= {ptr_q, bus.fifo_dout};
                    first_q <= (cnt_q == '0);
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    // A pending word is always delivered, even if enable
                    // drops; the following CHECK returns to IDLE.
                    if (bus.m_tready) begin
                        if (burst_last) begin
                            ptr_q   <= ptr_adv_d;
                            cnt_q   <= '0;
                            state_q <= S_SELECT;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            state_q <= S_CHECK;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Clear wins over a same-cycle set or increment.
            if (clear_status_i) begin
                overflow_q <= '0;
            end else if ((state_q == S_CHECK) && bus.fifo_full) begin
                overflow_q[ptr_q] <= 1'b1;
            end

            if (clear_status_i) begin
                words_q <= '0;
            end else if (handshake) begin
                words_q <= words_q + 32'd1;
            end
        end
    end

    assign bus.fifo_addr     = ptr_q;
    assign bus.fifo_rd_en    = rd_strobe;
    assign bus.m_tdata       = tdata_q;
    assign bus.m_tuser_first = first_q;
    assign bus.m_tvalid      = (state_q == S_OUT);

    assign busy_o          = (state_q != S_IDLE);
    assign overflow_seen_o = overflow_q;
    assign words_sent_o    = words_q;

endmodule

`default_nettype wire
